// File: rtl/gmm_pkg.sv
// rtl/gmm_pkg.sv - shared GMM types, ROM record layout, FSM states and score saturation
package gmm_pkg;

   typedef logic signed [15:0] num;

   // Default component count; also sizes the ROM record, so a scorer may use fewer.
   localparam int N_COMPONENTS_DEF = 25;
   localparam int COMP_W           = $clog2(N_COMPONENTS_DEF);
   localparam int ACC_W            = 48;

   typedef struct packed {
      num                                k;
      logic [N_COMPONENTS_DEF-1:0][15:0] omegas;
      num   [N_COMPONENTS_DEF-1:0]       means;
   } senone_data;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_ACCUM,
      S_FINISH
   } state_t;

   localparam logic signed [ACC_W+1:0] SAT_MAX = 50'sd32767;
   localparam logic signed [ACC_W+1:0] SAT_MIN = -50'sd32768;

   // Clamp a wide signed margin into the 16-bit score range.
   function automatic num sat16(input logic signed [ACC_W+1:0] v);
      num r;
      if (v > SAT_MAX)
         r = 16'h7FFF;
      else if (v < SAT_MIN)
         r = 16'h8000;
      else
         r = v[15:0];
      return r;
   endfunction

endpackage

// File: rtl/gmm_term.sv
// rtl/gmm_term.sv - one weighted squared-distance term: ((x-mean)^2 >> SQ_SHIFT) * omega
module gmm_term
   import gmm_pkg::*;
#(
   parameter int SQ_SHIFT = 16
) (
   input  num               i_x,
   input  num               i_mean,
   input  logic [15:0]      i_omega,
   output logic [ACC_W-1:0] o_term
);

   logic signed [16:0] w_diff;
   logic signed [33:0] w_sq;
   logic [33:0]        w_sq_shr;

   // Difference needs 17 bits so full-scale inputs cannot wrap; its square is never negative.
   assign w_diff   = {i_x[15], i_x} - {i_mean[15], i_mean};
   assign w_sq     = w_diff * w_diff;
   assign w_sq_shr = $unsigned(w_sq) >> SQ_SHIFT;
   assign o_term   = ACC_W'(w_sq_shr) * ACC_W'(i_omega);

endmodule

// File: rtl/senone_scorer.sv
// rtl/senone_scorer.sv - sweeps senone ROM per frame and emits saturated scores; optional BEST_SENONE_EN adds best tracking
module senone_scorer
   import gmm_pkg::*;
#(
   parameter int N_COMPONENTS = N_COMPONENTS_DEF,
   parameter int N_SENONES    = 12,
   parameter int SQ_SHIFT     = 16,
   parameter int SCALE_SHIFT  = 0
) (
   input  logic                      clk,
   input  logic                      nReset,
   input  logic                      start,
   input  logic [N_COMPONENTS*16-1:0] feature,
   output logic                      busy,
   output logic [4:0]                senone_index,
   input  senone_data                senone,
   output logic                      score_valid,
   output num                        score,
   output logic [4:0]                score_index,
   output logic                      done
`ifdef BEST_SENONE_EN
   ,
   output num                        best_score,
   output logic [4:0]                best_index
`endif
);

   state_t                     r_state, w_next;
   num [N_COMPONENTS_DEF-1:0]  r_feat, w_feat_in;
   senone_data                 r_sen;
   logic [COMP_W-1:0]          r_comp;
   logic [ACC_W-1:0]           r_acc, r_term, w_term, w_acc_total, w_acc_scaled;
   logic signed [ACC_W+1:0]    w_margin;
   num                         w_score, r_score;
   logic                       w_last_comp, w_last_senone;
   logic                       r_busy, r_valid, r_done;
   logic [4:0]                 r_idx, r_score_idx;

   // Unused component slots of the latched frame read as zero.
   for (genvar g = 0; g < N_COMPONENTS_DEF; g++) begin : g_feat
      if (g < N_COMPONENTS) begin : g_used
         assign w_feat_in[g] = feature[g*16 +: 16];
      end else begin : g_unused
         assign w_feat_in[g] = '0;
      end
   end

   gmm_term #(
      .SQ_SHIFT (SQ_SHIFT)
   ) u_term (
      .i_x     (r_feat[r_comp]),
      .i_mean  (r_sen.means[r_comp]),
      .i_omega (r_sen.omegas[r_comp]),
      .o_term  (w_term)
   );

   assign w_last_comp   = (r_comp == COMP_W'(N_COMPONENTS - 1));
   assign w_last_senone = (r_idx == 5'(N_SENONES - 1));

   // The last term is still in r_term when FINISH computes the score.
   assign w_acc_total  = r_acc + r_term;
   assign w_acc_scaled = w_acc_total >> SCALE_SHIFT;
   assign w_margin     = {{(ACC_W-14){r_sen.k[15]}}, r_sen.k} - {2'b00, w_acc_scaled};
   assign w_score      = sat16(w_margin);

   // State register.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (start) w_next = S_LOAD;
         S_LOAD:   w_next = S_ACCUM;
         S_ACCUM:  if (w_last_comp) w_next = S_FINISH;
         S_FINISH: w_next = w_last_senone ? S_IDLE : S_LOAD;
         default:  w_next = S_IDLE;
      endcase
   end

   // Datapath and registered outputs, sequenced by the current state.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_feat      <= '0;
         r_sen       <= '0;
         r_comp      <= '0;
         r_acc       <= '0;
         r_term      <= '0;
         r_busy      <= 1'b0;
         r_idx       <= '0;
         r_valid     <= 1'b0;
         r_done      <= 1'b0;
         r_score     <= '0;
         r_score_idx <= '0;
      end else begin
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_feat <= w_feat_in;
                  r_idx  <= '0;
                  r_busy <= 1'b1;
               end
            end
            S_LOAD: begin
               r_sen  <= senone;
               r_acc  <= '0;
               r_term <= '0;
               r_comp <= '0;
            end
            S_ACCUM: begin
               r_term <= w_term;
               r_acc  <= r_acc + r_term;
               if (!w_last_comp) r_comp <= r_comp + 1'b1;
            end
            S_FINISH: begin
               r_valid     <= 1'b1;
               r_score     <= w_score;
               r_score_idx <= r_idx;
               if (w_last_senone) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BEST_SENONE_EN
   num         r_best_score;
   logic [4:0] r_best_idx;

   // Running maximum over the frame; strict compare keeps the lowest index on ties.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         r_best_score <= '0;
         r_best_idx   <= '0;
      end else if (r_state == S_IDLE && start) begin
         r_best_score <= 16'sh8000;
         r_best_idx   <= '0;
      end else if (r_state == S_FINISH && w_score > r_best_score) begin
         r_best_score <= w_score;
         r_best_idx   <= r_idx;
      end
   end

   assign best_score = r_best_score;
   assign best_index = r_best_idx;
`endif

   assign busy         = r_busy;
   assign senone_index = r_idx;
   assign score_valid  = r_valid;
   assign score        = r_score;
   assign score_index  = r_score_idx;
   assign done         = r_done;

endmodule

// File: tb/tb_senone_scorer.sv
// tb/tb_senone_scorer.sv - scoreboard bench for senone_scorer with a stub senone ROM
module tb_senone_scorer;
   import gmm_pkg::*;

   localparam int NC = 6;
   localparam int NS = 12;

   logic             clk = 1'b0;
   logic             nReset = 1'b0;
   logic             start = 1'b0;
   logic [NC*16-1:0] feature = '0;
   logic             busy, score_valid, done;
   logic [4:0]       senone_index, score_index;
   num               score;
   senone_data       rom_out;
`ifdef BEST_SENONE_EN
   num               best_score;
   logic [4:0]       best_index;
`endif

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int t_start = 0;

   num          rk     [32];
   logic [15:0] rom_om [32][NC];
   num          rom_mu [32][NC];
   num          feat_v [NC];
   num          m0     [NC] = '{16'hEBCB, 16'hFA2D, 16'hFADD, 16'hF9E4, 16'h0EF7, 16'h17A3};

   typedef struct {
      int          idx;
      logic [15:0] score;
      int          rel;
   } exp_t;
   typedef struct {
      int          rel;
      int          bidx;
      logic [15:0] bscore;
   } done_t;

   exp_t  sb_q[$];
   done_t done_q[$];
   exp_t  mon_e;
   done_t mon_d;

   senone_scorer #(
      .N_COMPONENTS (NC),
      .N_SENONES    (NS),
      .SQ_SHIFT     (16),
      .SCALE_SHIFT  (0)
   ) dut (
      .clk          (clk),
      .nReset       (nReset),
      .start        (start),
      .feature      (feature),
      .busy         (busy),
      .senone_index (senone_index),
      .senone       (rom_out),
      .score_valid  (score_valid),
      .score        (score),
      .score_index  (score_index),
      .done         (done)
`ifdef BEST_SENONE_EN
      ,
      .best_score   (best_score),
      .best_index   (best_index)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub ROM, combinational from the index.
   always_comb begin
      rom_out   = '0;
      rom_out.k = rk[senone_index];
      for (int i = 0; i < NC; i++) begin
         rom_out.omegas[i] = rom_om[senone_index][i];
         rom_out.means[i]  = rom_mu[senone_index][i];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic rom_init();
      for (int s = 0; s < 32; s++) begin
         rk[s] = (s == 0) ? 16'hD075 : 16'hCDA9;
         for (int i = 0; i < NC; i++) begin
            rom_om[s][i] = (s == 0 && i == 0) ? 16'd2 : 16'd4;
            rom_mu[s][i] = m0[i] + 16'(s * 256);
         end
      end
   endtask

   task automatic set_feat(input int base_senone, input int offs);
      for (int i = 0; i < NC; i++) feat_v[i] = m0[i] + 16'(base_senone * 256 + offs);
   endtask

   function automatic logic [15:0] model_score(input int s);
      longint acc, d;
      acc = 0;
      for (int i = 0; i < NC; i++) begin
         d   = longint'(feat_v[i]) - longint'(rom_mu[s][i]);
         acc = acc + ((d * d) / 65536) * longint'(rom_om[s][i]);
      end
      d = longint'(rk[s]) - acc;
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
      return d[15:0];
   endfunction

   // Queue expectations for a frame, then issue start. n_pulses<NS means the frame is aborted.
   task automatic frame(input int n_pulses, input int hidx, input logic [15:0] hscore,
                        input int bidx, input logic [15:0] bscore);
      exp_t        e;
      done_t       d;
      logic [15:0] s, best_s;
      int          best_i;
      for (int i = 0; i < NC; i++) feature[i*16 +: 16] = feat_v[i];
      best_s = 16'h8000;
      best_i = 0;
      for (int k = 0; k < NS; k++) begin
         s = (k == hidx) ? hscore : model_score(k);
         if ($signed(s) > $signed(best_s)) begin
            best_s = s;
            best_i = k;
         end
         e.idx = k; e.score = s; e.rel = 9 + 8 * k;
         if (k < n_pulses) sb_q.push_back(e);
      end
      d.rel    = 97;
      d.bidx   = (bidx < 0) ? best_i : bidx;
      d.bscore = (bidx < 0) ? best_s : bscore;
      if (n_pulses == NS) done_q.push_back(d);
      @(negedge clk);
      start   = 1'b1;
      t_start = cyc;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_rel(input int r);
      while (cyc - t_start < r) @(negedge clk);
   endtask

   task automatic finish_frame(input string tag);
      wait_rel(96);
      check({tag, "_busy_c96"}, busy, 1'b1);
      wait_rel(98);
      check({tag, "_busy_c98"}, busy, 1'b0);
      wait_rel(106);
      check({tag, "_score_q_drained"}, sb_q.size(), 0);
      check({tag, "_done_q_drained"}, done_q.size(), 0);
   endtask

   // Monitor: pops expectations whenever the DUT presents a score or done.
   always @(negedge clk) begin
      check("senone_index_range", senone_index > 5'd11, 1'b0);
      if (score_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_score_valid: actual index=%0d score=%0h required no pulse",
                     score_index, score);
         end else begin
            mon_e = sb_q.pop_front();
            check("score_index", score_index, mon_e.idx);
            check("score", $unsigned(score), mon_e.score);
            check("score_cycle", cyc - t_start, mon_e.rel);
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: actual done=1 required 0");
         end else begin
            mon_d = done_q.pop_front();
            check("done_cycle", cyc - t_start, mon_d.rel);
`ifdef BEST_SENONE_EN
            check("best_index", best_index, mon_d.bidx);
            check("best_score", $unsigned(best_score), mon_d.bscore);
`endif
         end
      end
   end

   initial begin
      rom_init();
      set_feat(0, 0);
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_score_valid", score_valid, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_score", $unsigned(score), 16'h0000);
      check("rst_score_index", score_index, 5'd0);
      check("rst_senone_index", senone_index, 5'd0);
      nReset = 1'b1;
      repeat (2) @(negedge clk);

      // Feature equals senone 0 means: exact K.
      set_feat(0, 0);
      frame(NS, 0, 16'hD075, 0, 16'hD075);
      finish_frame("t1");

      // Single nonzero term: comp0 diff 0x100, omega 2.
      set_feat(0, 0);
      feat_v[0] = m0[0] + 16'sh0100;
      frame(NS, 0, 16'hD073, -1, 16'h0000);
      finish_frame("t2");

      // Full-scale difference and omega everywhere: saturate to 0x8000.
      for (int s = 0; s < NS; s++)
         for (int i = 0; i < NC; i++) begin
            rom_mu[s][i] = 16'sh8001;
            rom_om[s][i] = 16'hFFFF;
         end
      for (int i = 0; i < NC; i++) feat_v[i] = 16'sh0000;
      frame(NS, 11, 16'h8000, 0, 16'h8000);
      finish_frame("t4");
      rom_init();

      // Start and feature changes while busy are ignored.
      set_feat(3, 0);
      frame(NS, 3, 16'hCDA9, 3, 16'hCDA9);
      wait_rel(20);
      set_feat(9, 0);
      for (int i = 0; i < NC; i++) feature[i*16 +: 16] = feat_v[i];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_frame("t5a");

      // Reset in the middle of senone 5 aborts the frame.
      set_feat(5, 0);
      frame(5, -1, 16'h0000, -1, 16'h0000);
      wait_rel(44);
      nReset = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_score_valid", score_valid, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_score", $unsigned(score), 16'h0000);
      check("abort_score_index", score_index, 5'd0);
      check("abort_senone_index", senone_index, 5'd0);
      @(negedge clk);
      nReset = 1'b1;
      repeat (60) @(negedge clk);
      check("abort_score_q_drained", sb_q.size(), 0);

      // Feature equals senone 7 means: senone 7 is the frame maximum.
      set_feat(7, 0);
      frame(NS, 7, 16'hCDA9, 7, 16'hCDA9);
      finish_frame("t6");

      // Senones 7 and 8 tie at K: the lower index is reported.
      set_feat(7, 128);
      frame(NS, 8, 16'hCDA9, 7, 16'hCDA9);
      finish_frame("t6tie");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
